key_logic: RTL and testbench
============================

KEY_LOGIC -- requirements
Module: key_logic

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the number of key inputs (1..32).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of stable clocks required to accept a level (>=2).
REQ-003 The module SHALL have port csi_clk, input, 1 bit: the single clock.
REQ-004 The module SHALL have port rsi_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port coe_key, input, WIDTH bits: asynchronous key pins, active-low, idle high.
REQ-006 The module SHALL have port avs_address, input, 2 bits: register word address.
REQ-007 The module SHALL have ports avs_read and avs_write, input, 1 bit each: Avalon-MM strobes.
REQ-008 The module SHALL have port avs_writedata, input, 32 bits: write data.
REQ-009 The module SHALL have port avs_readdata, output, 32 bits: registered read data.
REQ-010 The module SHALL have port ins_irq, output, 1 bit: level interrupt, active-high.

Function
REQ-011 Each coe_key bit SHALL pass through a 2-FF synchronizer before any other use.
REQ-012 Per bit, a counter of width clog2(DEBOUNCE_CYCLES) SHALL count while the synced value differs from the debounced value, and clear while they are equal.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the debounced bit SHALL take the synced value on that edge, and the counter SHALL clear.
REQ-014 A clean pin transition SHALL appear on the debounced bit exactly 2+DEBOUNCE_CYCLES clocks after the first sampling edge; a glitch shorter than DEBOUNCE_CYCLES synced clocks SHALL have no effect.
REQ-015 The register map SHALL be: 0 DATA (RO, debounced state); 1 EDGE (RW1C, captured events); 2 MASK (RW, WIDTH bits); 3 CTRL (RW, bit0 EN, bit1 POL, bit2 BOTH).
REQ-016 An event SHALL be the debounced bit changing: falling when POL=0, rising when POL=1, or either direction when BOTH=1. The event SHALL set the matching EDGE bit in the same cycle the debounced bit updates.
REQ-017 When EN=0, counters SHALL be held at 0, debounced values SHALL be frozen, and no EDGE bits SHALL be set; DATA SHALL remain readable.
REQ-018 Writing 1 to an EDGE bit SHALL clear it; writing 0 SHALL leave it unchanged. If an event and a clear hit the same bit in the same cycle, the event SHALL win and the bit SHALL remain 1.
REQ-019 ins_irq SHALL be registered as OR(EDGE & MASK), asserting 1 clock after EDGE or MASK changes.
REQ-020 Reads SHALL have fixed latency 1: avs_readdata is valid the clock after avs_read. Unused upper bits SHALL read 0, and avs_readdata SHALL hold its value when not reading.
REQ-021 Writes SHALL take effect on the avs_write edge, with no wait states. Writes to DATA SHALL be ignored.

Reset
REQ-022 While rsi_reset_n=0, all state SHALL assume its reset value immediately, independent of csi_clk:
- synchronizers and debounced bits all-ones
- counters 0
- EDGE 0, MASK 0, CTRL 0x1
- avs_readdata 0, ins_irq 0
REQ-023 Reset deassertion SHALL NOT generate an event while keys are idle high.
REQ-024 Reset asserted mid-debounce SHALL discard partial counts; no event SHALL be created on release.

Structure
REQ-025 A shared package key_logic_pkg SHALL hold:
- register address constants
- CTRL bit indices
- the CTRL reset value
REQ-026 Per-bit synchronizer, counter and debounced flop SHALL be a sub-module key_debounce, instantiated WIDTH times, with an enable input and outputs for level and change pulse.

Verification (bench: WIDTH=4, DEBOUNCE_CYCLES=8)
REQ-027 Reset, then read all registers -> DATA=0xF, EDGE=0x0, MASK=0x0, CTRL=0x1, ins_irq=0.
REQ-028 Toggle key0 low 5 clocks / high 5 clocks, repeated 4 times -> DATA stays 0xF, EDGE stays 0x0.
REQ-029 Hold key0 low 20 clocks -> DATA=0xE exactly 10 clocks after the first low sample, EDGE=0x1. Then write MASK=0x1 -> ins_irq=1 on the next clock.
REQ-030 Write EDGE=0x1 -> EDGE=0x0 and ins_irq=0 on the next clock. Repeat with the clear write aligned to a new key0 event -> EDGE bit0 remains 1.
REQ-031 Write CTRL=0x5, press then release key2 (each held 20 clocks), clearing EDGE between -> EDGE=0x4 after each transition. With CTRL=0x0 -> no change to DATA or EDGE.
REQ-032 Assert rsi_reset_n at counter=5 on key1, then release with the key still low -> registers return to reset values at once, and EDGE=0x0 on release.

Source files
------------

// File: rtl/key_logic_pkg.sv
// key_logic_pkg
// Shared constants for the key_logic block: Avalon-MM register word
// addresses, CTRL bit positions and the CTRL reset value.
package key_logic_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // CTRL register layout
  localparam int CTRL_W    = 3;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_POL  = 1;
  localparam int CTRL_BOTH = 2;

  // Block comes out of reset enabled, falling-edge events only
  localparam logic [CTRL_W-1:0] CTRL_RESET = 3'b001;

endpackage

// File: rtl/key_logic_debounce.sv
// key_debounce
// One key channel: 2-FF synchronizer, stability counter and debounced
// level flop.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   key_i   : raw asynchronous pin (idle high)
//   en_i    : 0 holds the counter at zero and freezes the level
//   level_o : debounced level
//   chg_o   : combinational pulse, high in the cycle whose edge updates level_o
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  input  logic en_i,
  output logic level_o,
  output logic chg_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;
  logic             accept;

  assign mismatch = sync_q[1] ^ level_q;
  // The level is accepted on the edge where the counter already sits at
  // its terminal value, so a clean transition needs DEBOUNCE_CYCLES
  // consecutive mismatching synced samples.
  assign accept   = en_i & mismatch & (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!en_i || !mismatch) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and level reset to idle-high so reset release never
  // looks like a key release/press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign chg_o   = accept;

endmodule

// File: rtl/key_logic.sv
// key_logic
// Debounced key input peripheral with Avalon-MM slave and level interrupt.
//   csi_clk       : clock
//   rsi_reset_n   : asynchronous active-low reset
//   coe_key       : WIDTH asynchronous key pins, active-low, idle high
//   avs_address   : register word (0 DATA, 1 EDGE, 2 MASK, 3 CTRL)
//   avs_read      : read strobe, data returned the following clock
//   avs_write     : write strobe, no wait states
//   avs_writedata : write data
//   avs_readdata  : registered read data, held between reads
//   ins_irq       : registered OR of EDGE & MASK
module key_logic
  import key_logic_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             csi_clk,
  input  logic             rsi_reset_n,
  input  logic [WIDTH-1:0] coe_key,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             ins_irq
);

  logic [WIDTH-1:0]  lvl;
  logic [WIDTH-1:0]  chg;
  logic [WIDTH-1:0]  evt;
  logic [WIDTH-1:0]  clr;
  logic [WIDTH-1:0]  edge_q, edge_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              en, pol, both;
  logic              unused_wdata;

  assign en   = ctrl_q[CTRL_EN];
  assign pol  = ctrl_q[CTRL_POL];
  assign both = ctrl_q[CTRL_BOTH];

  // Upper write-data bits have no register behind them.
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (csi_clk),
      .rst_ni (rsi_reset_n),
      .key_i  (coe_key[i]),
      .en_i   (en),
      .level_o(lvl[i]),
      .chg_o  (chg[i])
    );
  end

  // chg is only high with en set, so events are suppressed while disabled.
  // lvl still holds the old value while chg is high: old 1 means falling.
  always_comb begin
    if (both) begin
      evt = chg;
    end else if (pol) begin
      evt = chg & ~lvl;
    end else begin
      evt = chg & lvl;
    end
  end

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    if (avs_write) begin
      case (avs_address)
        ADDR_EDGE: clr    = avs_writedata[WIDTH-1:0];
        ADDR_MASK: mask_d = avs_writedata[WIDTH-1:0];
        ADDR_CTRL: ctrl_d = avs_writedata[CTRL_W-1:0];
        default:   ;
      endcase
    end
    // A new event beats a simultaneous write-1-to-clear.
    edge_d = (edge_q & ~clr) | evt;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        ADDR_DATA: rdata_d[WIDTH-1:0]  = lvl;
        ADDR_EDGE: rdata_d[WIDTH-1:0]  = edge_q;
        ADDR_MASK: rdata_d[WIDTH-1:0]  = mask_q;
        default:   rdata_d[CTRL_W-1:0] = ctrl_q;
      endcase
    end
  end

  assign irq_d = |(edge_q & mask_q);

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      edge_q  <= '0;
      mask_q  <= '0;
      ctrl_q  <= CTRL_RESET;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign ins_irq      = irq_q;

endmodule

// File: tb/tb_key_logic.sv
`timescale 1ns/1ps
module tb_key_logic;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic             csi_clk = 1'b0;
  logic             rsi_reset_n;
  logic [WIDTH-1:0] coe_key;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             ins_irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic rd_seen;

  key_logic #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .csi_clk      (csi_clk),
    .rsi_reset_n  (rsi_reset_n),
    .coe_key      (coe_key),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .ins_irq      (ins_irq)
  );

  always #5 csi_clk = ~csi_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Remember which edges captured a read; compare on the following negedge.
  always @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) rd_seen <= 1'b0;
    else              rd_seen <= avs_read;
  end

  always @(negedge csi_clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.tag, avs_readdata, e.exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic rd(input logic [1:0] addr, input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge csi_clk);
    avs_read    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge csi_clk);
    avs_write     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rsi_reset_n   = 1'b0;
    coe_key       = '1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    idle(2);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_irq", {31'b0, ins_irq}, 32'h0);
    rsi_reset_n = 1'b1;
    idle(1);

    // Register values after reset
    rd(A_DATA, "init_data", 32'hF);
    rd(A_EDGE, "init_edge", 32'h0);
    rd(A_MASK, "init_mask", 32'h0);
    rd(A_CTRL, "init_ctrl", 32'h1);
    idle(1);
    chk("init_irq", {31'b0, ins_irq}, 32'h0);

    // Bounce shorter than the debounce window
    repeat (4) begin
      coe_key[0] = 1'b0; idle(5);
      coe_key[0] = 1'b1; idle(5);
    end
    idle(12);
    rd(A_DATA, "glitch_data", 32'hF);
    rd(A_EDGE, "glitch_edge", 32'h0);

    // Clean press: first sampling edge is edge 1, level flips on edge 10,
    // visible in a read captured on edge 11 or later.
    coe_key[0] = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      rd(A_DATA, "press_timing", (i >= 11) ? 32'hE : 32'hF);
    end
    idle(6);
    rd(A_EDGE, "press_edge", 32'h1);
    wr(A_MASK, 32'h1);
    chk("mask_irq_before", {31'b0, ins_irq}, 32'h0);
    idle(1);
    chk("mask_irq_after", {31'b0, ins_irq}, 32'h1);

    // Release is a rising change, not an event with POL=0
    coe_key[0] = 1'b1;
    idle(20);
    rd(A_DATA, "release_data", 32'hF);
    rd(A_EDGE, "release_edge", 32'h1);

    // Write-1-to-clear
    wr(A_EDGE, 32'h1);
    chk("clr_irq_before", {31'b0, ins_irq}, 32'h1);
    idle(1);
    chk("clr_irq_after", {31'b0, ins_irq}, 32'h0);
    rd(A_EDGE, "clr_edge", 32'h0);

    // Clear on the very edge where a new event lands
    coe_key[0] = 1'b0;
    idle(9);
    wr(A_EDGE, 32'h1);
    rd(A_EDGE, "race_edge", 32'h1);
    rd(A_DATA, "race_data", 32'hE);
    coe_key[0] = 1'b1;
    idle(20);
    wr(A_EDGE, 32'h1);
    rd(A_EDGE, "race_clr", 32'h0);

    // DATA read-only, unused upper bits read zero
    wr(A_DATA, 32'h0);
    rd(A_DATA, "data_ro", 32'hF);
    wr(A_MASK, 32'hFFFF_FFFF);
    rd(A_MASK, "mask_width", 32'hF);
    wr(A_MASK, 32'h0);

    // Both-edge mode on key2
    wr(A_CTRL, 32'h5);
    rd(A_CTRL, "ctrl_both", 32'h5);
    coe_key[2] = 1'b0;
    idle(20);
    rd(A_DATA, "both_press_data", 32'hB);
    rd(A_EDGE, "both_press_edge", 32'h4);
    wr(A_EDGE, 32'h4);
    coe_key[2] = 1'b1;
    idle(20);
    rd(A_DATA, "both_rel_data", 32'hF);
    rd(A_EDGE, "both_rel_edge", 32'h4);
    wr(A_EDGE, 32'h4);
    rd(A_EDGE, "both_clr", 32'h0);

    // Rising-only mode on key3
    wr(A_CTRL, 32'h3);
    coe_key[3] = 1'b0;
    idle(20);
    rd(A_DATA, "pol_press_data", 32'h7);
    rd(A_EDGE, "pol_press_edge", 32'h0);
    coe_key[3] = 1'b1;
    idle(20);
    rd(A_EDGE, "pol_rel_edge", 32'h8);
    wr(A_EDGE, 32'h8);

    // Disabled: nothing moves
    wr(A_CTRL, 32'h0);
    coe_key[2] = 1'b0;
    idle(20);
    rd(A_DATA, "dis_press_data", 32'hF);
    rd(A_EDGE, "dis_press_edge", 32'h0);
    coe_key[2] = 1'b1;
    idle(20);
    rd(A_DATA, "dis_rel_data", 32'hF);
    rd(A_EDGE, "dis_rel_edge", 32'h0);

    // Build up some state so reset has something to clear
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'h1);
    coe_key[0] = 1'b0;
    idle(20);
    coe_key[0] = 1'b1;
    idle(20);
    rd(A_EDGE, "pre_rst_edge", 32'h1);
    idle(1);
    chk("pre_rst_irq", {31'b0, ins_irq}, 32'h1);

    // Reset mid-debounce on key1 (counter at 5 after edge 7)
    coe_key[1] = 1'b0;
    idle(7);
    rsi_reset_n = 1'b0;
    #1;
    chk("mid_rst_rdata", avs_readdata, 32'h0);
    chk("mid_rst_irq", {31'b0, ins_irq}, 32'h0);
    idle(3);
    rsi_reset_n = 1'b1;
    rd(A_DATA, "post_rst_data", 32'hF);
    rd(A_EDGE, "post_rst_edge", 32'h0);
    rd(A_MASK, "post_rst_mask", 32'h0);
    rd(A_CTRL, "post_rst_ctrl", 32'h1);
    idle(1);
    chk("post_rst_irq", {31'b0, ins_irq}, 32'h0);
    coe_key[1] = 1'b1;
    idle(20);
    rd(A_DATA, "final_data", 32'hF);
    rd(A_EDGE, "final_edge", 32'h0);
    idle(2);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
